reg_bank_writer: RTL and testbench
==================================

# reg_bank_writer

Write side of the register unit: decodes the destination register index into a one-hot write enable and commits write-back data into a bank of registers on the rising clock edge. The bank contents are exported flattened, one word per register, for the read-side N-to-1 selectors. Register 0 is hard-wired to zero. The block also reports each committed write as a one-cycle strobe and keeps a running count of committed writes.

## Interface
- AMOUNT_OF_BITS, 32, width of each register and of write data
- AMOUNT_OF_REGS, 32, number of registers (≥ 3; need not be a power of two)
- SP_INIT, 32'h0000_0400, reset value of register 2 (stack pointer); truncated/zero-extended to AMOUNT_OF_BITS
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- we  in  1  write enable from control unit
- rd  in  $clog2(AMOUNT_OF_REGS)  destination register index
- wd  in  AMOUNT_OF_BITS  write-back data
- regs_flat  out  AMOUNT_OF_REGS*AMOUNT_OF_BITS  bank contents; register i at bits [i*AMOUNT_OF_BITS +: AMOUNT_OF_BITS]
- wr_strobe  out  AMOUNT_OF_REGS  registered one-hot of the register written at the last edge; all-zero if none
- wr_count  out  16  number of committed writes since reset

## Operation
- Decode: `sel[i] = we && (rd == i)` for 0 ≤ i < AMOUNT_OF_REGS. Combinational, internal.
- Commit: at a rising edge, if `sel[i]` and i ≠ 0, then `reg[i] <= wd`. All other registers hold.
- Register 0: never written. Reads as 0 at all times, including right after a write attempt to it.
- Out-of-range index: rd ≥ AMOUNT_OF_REGS is possible only when AMOUNT_OF_REGS is not a power of two. Such a write is dropped: no register changes, no strobe, no count.
- A write is counted (committed) only if we=1, rd ≠ 0, and rd < AMOUNT_OF_REGS.
- wr_strobe: at each edge, takes the one-hot of rd for a committed write, otherwise all-zero. It is a one-cycle pulse per write. Back-to-back writes give consecutive strobes.
- wr_count: increments by 1 per committed write. It wraps from 16'hFFFF to 0 with no saturation.
- Writing a value equal to the current contents still counts as a committed write and still strobes.
- No read bypass: regs_flat shows only committed state. A consumer that samples regs_flat in the same cycle as a write to the same index sees the old value.
- Reset (rst_n=0, asynchronous, effective immediately and independent of clk):
  - all registers go to 0, except register 2, which goes to SP_INIT;
  - wr_strobe goes to 0 and wr_count goes to 0.
  - Any write in progress is lost.
  - While rst_n=0, clock edges have no effect.

## Timing
- Write latency: new data is visible on regs_flat one clock-to-q delay after the committing edge. wr_strobe and the wr_count increment appear at the same edge.
- we, rd and wd are sampled only at the rising edge. They must meet setup/hold to clk. Glitches between edges have no effect.
- Reset deassertion should be synchronized externally to clk. The first edge with rst_n=1 may commit a write.
- Reset asserted in the same cycle as a write: reset wins. The register keeps its reset value and the count is 0.
- regs_flat is driven purely from flops; there is no combinational path from inputs to outputs.
- Throughput: one write per cycle, sustained.

## Test plan
- Reset values: hold rst_n=0, then release.
  - -> Every word of regs_flat is 0 except word 2 = 32'h0000_0400.
  - -> wr_strobe=0 and wr_count=0.
- Basic write: we=1, rd=5, wd=32'hDEAD_BEEF for one edge.
  - -> Word 5 = DEADBEEF and all other words are unchanged.
  - -> wr_strobe=32'h0000_0020 for exactly one cycle; wr_count=1.
- x0 guard: we=1, rd=0, wd=32'hFFFF_FFFF.
  - -> Word 0 stays 0; wr_strobe stays 0; wr_count is unchanged.
- Write-disable: we=0, rd=7, wd=32'h1234_5678.
  - -> Word 7 is unchanged and there is no strobe.
  - -> Then 31 back-to-back writes with rd=1..31 and wd=rd*3:
    - each word i ends = 3i;
    - wr_strobe walks one-hot, bit 1 through bit 31;
    - wr_count=31.
- Mid-run reset: write rd=2 with wd=32'h0000_0800, then pulse rst_n low between edges.
  - -> Word 2 returns to 32'h0000_0400 immediately, without waiting for clk; wr_count=0.
  - -> A write presented during reset is not committed.
- Non-power-of-two bank, count wrap:
  - With AMOUNT_OF_REGS=20, write we=1, rd=25: -> dropped, no strobe, no count.
  - Preload a write count of 16'hFFFF, then perform one more valid write: -> wr_count=0.

Source files
------------

// File: rtl/reg_bank_writer.sv
// reg_bank_writer: write side of the register unit.
// Decodes rd into a one-hot write select and commits wd into the register bank
// on the rising edge. Register 0 always reads zero. Every committed write is
// reported as a one-cycle one-hot strobe and counted in a 16-bit wrapping
// counter.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   we, rd, wd  - write enable, destination index, write-back data
//   regs_flat   - bank contents, register i at [i*AMOUNT_OF_BITS +: AMOUNT_OF_BITS]
//   wr_strobe   - registered one-hot of the register written at the last edge
//   wr_count    - committed writes since reset (wraps)
module reg_bank_writer #(
  parameter int unsigned AMOUNT_OF_BITS = 32,
  parameter int unsigned AMOUNT_OF_REGS = 32,
  parameter logic [31:0] SP_INIT        = 32'h0000_0400
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     we,
  input  logic [$clog2(AMOUNT_OF_REGS)-1:0]        rd,
  input  logic [AMOUNT_OF_BITS-1:0]                wd,
  output logic [AMOUNT_OF_REGS*AMOUNT_OF_BITS-1:0] regs_flat,
  output logic [AMOUNT_OF_REGS-1:0]                wr_strobe,
  output logic [15:0]                              wr_count
);

  localparam int unsigned IDX_W  = $clog2(AMOUNT_OF_REGS);
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SP_IDX = 2;
  localparam logic [AMOUNT_OF_BITS-1:0] SP_RST = AMOUNT_OF_BITS'(SP_INIT);

  logic [AMOUNT_OF_BITS-1:0] regs_q [AMOUNT_OF_REGS];
  logic [AMOUNT_OF_BITS-1:0] regs_d [AMOUNT_OF_REGS];
  logic [AMOUNT_OF_REGS-1:0] sel_c;
  logic                      commit_c;
  logic [AMOUNT_OF_REGS-1:0] wr_strobe_q, wr_strobe_d;
  logic [CNT_W-1:0]          wr_count_q, wr_count_d;

  // Decode and next state. Index 0 is excluded from commit; an out-of-range rd
  // matches no select bit, so it is dropped without a separate range check.
  always_comb begin
    sel_c       = '0;
    wr_strobe_d = '0;
    for (int i = 0; i < int'(AMOUNT_OF_REGS); i++) begin
      sel_c[i] = we && (rd == IDX_W'(i));
    end
    commit_c = |(sel_c & ~AMOUNT_OF_REGS'(1));

    for (int i = 0; i < int'(AMOUNT_OF_REGS); i++) begin
      regs_d[i] = regs_q[i];
      if (i == 0) begin
        regs_d[i] = '0;
      end else if (sel_c[i]) begin
        regs_d[i]      = wd;
        wr_strobe_d[i] = 1'b1;
      end
    end

    wr_count_d = wr_count_q + CNT_W'(commit_c);
  end

  // State registers; the stack pointer resets to SP_INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(AMOUNT_OF_REGS); i++) begin
        regs_q[i] <= (i == int'(SP_IDX)) ? SP_RST : '0;
      end
      wr_strobe_q <= '0;
      wr_count_q  <= '0;
    end else begin
      for (int i = 0; i < int'(AMOUNT_OF_REGS); i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr_strobe_q <= wr_strobe_d;
      wr_count_q  <= wr_count_d;
    end
  end

  // Flatten the bank for the read-side selectors.
  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < int'(AMOUNT_OF_REGS); i++) begin
      regs_flat[i*AMOUNT_OF_BITS +: AMOUNT_OF_BITS] = regs_q[i];
    end
  end

  assign wr_strobe = wr_strobe_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_reg_bank_writer.sv
module tb_reg_bank_writer;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 32;
  localparam int unsigned NB = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              we;
  logic [4:0]        rd;
  logic [W-1:0]      wd;
  logic [N*W-1:0]    regs_flat;
  logic [N-1:0]      wr_strobe;
  logic [15:0]       wr_count;

  logic              we_b;
  logic [4:0]        rd_b;
  logic [W-1:0]      wd_b;
  logic [NB*W-1:0]   regs_flat_b;
  logic [NB-1:0]     wr_strobe_b;
  logic [15:0]       wr_count_b;

  logic [W-1:0]      exp_r [N];
  logic [15:0]       exp_cnt;
  int                n_chk  = 0;
  int                n_pass = 0;

  always #5 clk = ~clk;

  reg_bank_writer #(.AMOUNT_OF_BITS(W), .AMOUNT_OF_REGS(N), .SP_INIT(32'h0000_0400)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .rd(rd), .wd(wd),
    .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_count(wr_count)
  );

  reg_bank_writer #(.AMOUNT_OF_BITS(W), .AMOUNT_OF_REGS(NB), .SP_INIT(32'h0000_0400)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we_b), .rd(rd_b), .wd(wd_b),
    .regs_flat(regs_flat_b), .wr_strobe(wr_strobe_b), .wr_count(wr_count_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < int'(N); i++)
      chk($sformatf("%s word%0d", tag, i), 64'(regs_flat[i*W +: W]), 64'(exp_r[i]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(N); i++) exp_r[i] = '0;
    exp_r[2] = 32'h0000_0400;
    exp_cnt  = 16'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] onehot(input int i);
    logic [63:0] one;
    one = 64'd1;
    return one << i;
  endfunction

  initial begin
    rst_n = 1'b0; we = 1'b0; rd = '0; wd = '0;
    we_b = 1'b0; rd_b = '0; wd_b = '0;
    model_reset();

    // Reset values, and clock edges during reset change nothing
    we = 1'b1; rd = 5'd9; wd = 32'h1111_1111;
    step(); step();
    check_bank("reset");
    chk("reset strobe", 64'(wr_strobe), 64'd0);
    chk("reset count", 64'(wr_count), 64'd0);
    we = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // No bypass: before the edge the old value is still shown
    we = 1'b1; rd = 5'd5; wd = 32'hDEAD_BEEF;
    #1 chk("no bypass word5", 64'(regs_flat[5*W +: W]), 64'd0);
    step();
    exp_r[5] = 32'hDEAD_BEEF; exp_cnt = 16'd1;
    check_bank("basic");
    chk("basic strobe", 64'(wr_strobe), 64'h0000_0020);
    chk("basic count", 64'(wr_count), 64'd1);
    we = 1'b0;
    step();
    chk("basic strobe one cycle", 64'(wr_strobe), 64'd0);

    // x0 guard
    we = 1'b1; rd = 5'd0; wd = 32'hFFFF_FFFF;
    step();
    chk("x0 word0", 64'(regs_flat[0 +: W]), 64'd0);
    chk("x0 strobe", 64'(wr_strobe), 64'd0);
    chk("x0 count", 64'(wr_count), 64'd1);

    // Write disabled
    we = 1'b0; rd = 5'd7; wd = 32'h1234_5678;
    step();
    chk("wdis word7", 64'(regs_flat[7*W +: W]), 64'd0);
    chk("wdis strobe", 64'(wr_strobe), 64'd0);
    chk("wdis count", 64'(wr_count), 64'd1);

    // Reset pulse between edges clears immediately
    @(negedge clk) rst_n = 1'b0;
    #1 chk("async rst word5", 64'(regs_flat[5*W +: W]), 64'd0);
    chk("async rst count", 64'(wr_count), 64'd0);
    #1 rst_n = 1'b1;
    model_reset();

    // 31 back-to-back writes
    for (int i = 1; i < int'(N); i++) begin
      we = 1'b1; rd = 5'(i); wd = 32'(3 * i);
      step();
      exp_r[i] = 32'(3 * i);
      chk($sformatf("b2b strobe %0d", i), 64'(wr_strobe), onehot(i));
      chk($sformatf("b2b count %0d", i), 64'(wr_count), 64'(i));
    end
    we = 1'b0;
    step();
    exp_cnt = 16'd31;
    check_bank("b2b");
    chk("b2b final count", 64'(wr_count), 64'd31);
    chk("b2b idle strobe", 64'(wr_strobe), 64'd0);

    // Same-value write still counts and strobes
    we = 1'b1; rd = 5'd4; wd = 32'd12;
    step();
    chk("same val strobe", 64'(wr_strobe), 64'h0000_0010);
    chk("same val count", 64'(wr_count), 64'd32);
    chk("same val word4", 64'(regs_flat[4*W +: W]), 64'd12);

    // Mid-run reset: SP returns to SP_INIT without a clock edge
    we = 1'b1; rd = 5'd2; wd = 32'h0000_0800;
    step();
    chk("sp write", 64'(regs_flat[2*W +: W]), 64'h0000_0800);
    we = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrst sp", 64'(regs_flat[2*W +: W]), 64'h0000_0400);
    chk("midrst count", 64'(wr_count), 64'd0);
    chk("midrst strobe", 64'(wr_strobe), 64'd0);
    model_reset();
    we = 1'b1; rd = 5'd3; wd = 32'hCAFE_F00D;
    step();
    chk("rst write word3", 64'(regs_flat[3*W +: W]), 64'd0);
    chk("rst write count", 64'(wr_count), 64'd0);
    chk("rst write strobe", 64'(wr_strobe), 64'd0);
    we = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step();
    check_bank("after midrst");
    chk("after midrst count", 64'(wr_count), 64'd0);

    // 20-register bank: out-of-range and top-boundary indices
    we_b = 1'b1; rd_b = 5'd25; wd_b = 32'hAAAA_5555;
    step();
    chk("b oor strobe", 64'(wr_strobe_b), 64'd0);
    chk("b oor count", 64'(wr_count_b), 64'd0);
    for (int i = 0; i < int'(NB); i++)
      chk($sformatf("b oor word%0d", i), 64'(regs_flat_b[i*W +: W]),
          (i == 2) ? 64'h0000_0400 : 64'd0);
    rd_b = 5'd20;
    step();
    chk("b rd20 strobe", 64'(wr_strobe_b), 64'd0);
    chk("b rd20 count", 64'(wr_count_b), 64'd0);
    rd_b = 5'd19; wd_b = 32'h0000_0013;
    step();
    chk("b rd19 strobe", 64'(wr_strobe_b), 64'h0008_0000);
    chk("b rd19 count", 64'(wr_count_b), 64'd1);
    chk("b rd19 word", 64'(regs_flat_b[19*W +: W]), 64'h0000_0013);
    we_b = 1'b0;

    // Count wrap: run the count up to FFFF, then one more valid write
    we = 1'b1; rd = 5'd1; wd = 32'h0000_0005;
    repeat (65535) @(posedge clk);
    #1 chk("count at ffff", 64'(wr_count), 64'hFFFF);
    wd = 32'h0000_0006;
    step();
    chk("count wrap", 64'(wr_count), 64'd0);
    chk("wrap strobe", 64'(wr_strobe), 64'h0000_0002);
    chk("wrap word1", 64'(regs_flat[1*W +: W]), 64'd6);
    we = 1'b0;
    step();
    chk("wrap idle strobe", 64'(wr_strobe), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
